dadda_mult_pipe: RTL and testbench
==================================

Name: dadda_mult_pipe

Overview:
- Parametrised, pipelined unsigned Dadda multiplier with a valid/ready handshake. It is the next generation of the team's fixed 8x8 combinational Dadda multiplier.
- Operand width is generic. Partial-product reduction and the final carry-propagate add are split over registered stages. Backpressure is supported.
- An optional compile-time approximate mode replaces the low product columns with carry-free OR compression, for accuracy/power trade studies.
- Sits between operand producers and accumulators in the approximate-arithmetic datapath.

Parameters:
- WIDTH, 8, operand width in bits; legal range 4..32; product width is 2*WIDTH.
- TAG_W, 4, width of the sideband tag carried alongside each operation.
- APPROX_COLS, 0, number of low product columns approximated; legal 0..WIDTH; ignored unless DADDA_APPROX_EN is defined.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous assert, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands this cycle.
- in_a  in  WIDTH  multiplicand, unsigned.
- in_b  in  WIDTH  multiplier, unsigned.
- in_tag  in  TAG_W  sideband, returned unchanged with the product.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_y  out  2*WIDTH  product.
- out_tag  out  TAG_W  tag of the op in out_y.
- busy  out  1  OR of all stage valid flags.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: all stage valid flags clear, in_ready=1, out_valid=0, out_y=0, out_tag=0, busy=0. Data registers clear to 0.
- Pipeline, 3 stages, each with a valid flag v1..v3:
  - S1 registers in_a, in_b, in_tag.
  - S2 registers two 2*WIDTH rows (sum row, carry row). These come from Dadda reduction of the WIDTH*WIDTH AND partial products using the height sequence 2,3,4,6,9,13,19,28,... The reduction uses half adders and full adders only, with the minimum counter count per Dadda rules.
  - S3 registers the carry-propagate sum of the two rows. out_y, out_tag and out_valid are driven directly from S3 registers.
- Latency: 3 cycles from the accept edge (in_valid & in_ready) to out_valid=1, when out_ready is held 1.
- Throughput: 1 op/cycle.
- Handshake:
  - Stage n loads when !vn | adv(n+1). adv3 = out_ready.
  - in_ready = !v1 | (!v2 | (!v3 | out_ready)). This is combinational from out_ready, which is permitted.
  - Bubbles collapse: an empty stage accepts even when downstream is stalled.
  - While out_valid & !out_ready, out_y and out_tag hold stable.
  - in_valid must not depend on in_ready. Data is not required to be held when in_valid drops before acceptance.
- Ordering: strict FIFO order. The tag travels with its operands. No op is dropped or duplicated under any stall pattern.
- Width rules:
  - Product is full 2*WIDTH; no truncation, no overflow possible.
  - The top column carry-out of the final adder is product bit 2*WIDTH-1.
  - Columns with height 1 bypass the counters.
- Simultaneous events: a full pipeline with out_ready=1 and in_valid=1 accepts and emits in the same cycle.
- Reset mid-operation: all in-flight ops are discarded immediately and nothing is emitted after deassertion. The first accept after reset release yields out_valid 3 cycles later.

Optional Feature:
- Macro: DADDA_APPROX_EN.
- Defined, with K=APPROX_COLS:
  - For k<K, out_y[k] = OR of all partial products a[j]&b[i] with i+j=k.
  - No carries propagate from columns <K into column K.
  - out_y[2W-1:K] = exact sum of the partial products in columns >=K, shifted right by K.
  - Latency and handshake are unchanged. K=0 gives the exact result.
- Undefined: APPROX_COLS has no effect and no approximation logic is instantiated. Results are always exact.

Test Plan:
- WIDTH=8, exact: accept a=0xFF, b=0xFF, tag=0x5 -> out_y=0xFE01, tag 0x5, exactly 3 cycles after accept. Then a=0, b=0xA5 -> 0x0000.
- WIDTH=16, exact, back-to-back with out_ready=1: (0xFFFF,0xFFFF), (0x1234,0x0002), (0x8000,0x8000) -> 0xFFFE0001, 0x00002468, 0x40000000 on consecutive cycles, in_ready constantly 1.
- Backpressure, WIDTH=8: stream 10 ops with tags 0..9, out_ready random 30% high -> every product correct, tags 0..9 in order. out_y stable while stalled. in_ready=0 only when v1..v3 are all set and out_ready=0.
- Bubble collapse: fill S3 with one op and hold out_ready=0 -> in_ready stays 1 for 2 more accepts, then 0. busy=1 throughout.
- Async reset mid-flight: 3 ops in flight, drop rst_n between edges -> out_valid=0 and busy=0 immediately. No product is emitted after release. A new op (3,5) gives 0x000F at latency 3.
- DADDA_APPROX_EN, WIDTH=8, APPROX_COLS=4: 0xFF*0xFF -> 0xFDDF (exact 0xFE01). 0x01*0x01 -> 0x0001. Random 1000 ops match the OR-column reference model.

Source files
------------

// File: rtl/dadda_mult_pipe.sv
// rtl/dadda_mult_pipe.sv - 3-stage pipelined unsigned Dadda multiplier, valid/ready handshake
// Optional DADDA_APPROX_EN: low APPROX_COLS columns become carry-free OR columns.
module dadda_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int TAG_W       = 4,
  parameter int APPROX_COLS = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_y,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW);
`ifdef DADDA_APPROX_EN
  localparam int LOW_COLS = APPROX_COLS;
`else
  localparam int LOW_COLS = 0;
`endif

  if (WIDTH < 4 || WIDTH > 32 || APPROX_COLS < 0 || APPROX_COLS > WIDTH) begin : g_bad_params
    $error("dadda_mult_pipe: illegal WIDTH or APPROX_COLS");
  end

  function automatic logic bit_at(input logic [WIDTH-1:0] v, input int pos);
    logic [WIDTH-1:0] t;
    t = v >> pos;
    return t[0];
  endfunction

  function automatic logic [WIDTH-1:0] with_bit(input logic [WIDTH-1:0] v, input int pos,
                                                input logic b);
    return v | (WIDTH'(b) << pos);
  endfunction

  function automatic int dadda_height(input int s);
    int hh = 2;
    for (int k = 0; k < s; k++) hh = hh * 3 / 2;
    return hh;
  endfunction

  function automatic int dadda_stages();
    int n = 0;
    for (int s = 0; s < 16; s++) if (dadda_height(s) < WIDTH) n = s + 1;
    return n;
  endfunction

  localparam int NS = dadda_stages();

  logic               v1_q, v2_q, v3_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [TAG_W-1:0]   tag1_q, tag2_q, tag3_q;
  logic [PW-1:0]      row0_q, row1_q, row0_d, row1_d;
  logic [PW-1:0]      y_q, y_d;
  logic               ld1, ld2, ld3;

  // Column bit-bags: mat[c] holds cnt[c] live bits packed from bit 0 upward.
  logic [WIDTH-1:0]   mat  [PW];
  logic [WIDTH-1:0]   nmat [PW];
  int                 cnt  [PW];
  int                 ncnt [PW];
  int                 d, h, idx, col;
  logic               p0, p1, p2, sb, cb;

  always_comb begin
    d = 0; h = 0; idx = 0; col = 0;
    p0 = 1'b0; p1 = 1'b0; p2 = 1'b0; sb = 1'b0; cb = 1'b0;
    row0_d = '0;
    row1_d = '0;
    for (int c = 0; c < PW; c++) begin
      mat[CW'(c)]  = '0;
      nmat[CW'(c)] = '0;
      cnt[CW'(c)]  = 0;
      ncnt[CW'(c)] = 0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        col = i + j;
        if (col >= LOW_COLS) begin
          mat[CW'(col)] = with_bit(mat[CW'(col)], cnt[CW'(col)], bit_at(a_q, j) & bit_at(b_q, i));
          cnt[CW'(col)] = cnt[CW'(col)] + 1;
        end
      end
    end
    // Each stage squeezes every column down to height d; carries land in the next column.
    for (int st = NS - 1; st >= 0; st--) begin
      d = dadda_height(st);
      for (int c = 0; c < PW; c++) begin
        nmat[CW'(c)] = '0;
        ncnt[CW'(c)] = 0;
      end
      for (int c = 0; c < PW; c++) begin
        idx = 0;
        h   = cnt[CW'(c)] + ncnt[CW'(c)];
        for (int it = 0; it < WIDTH; it++) begin
          if (h > d) begin
            p0 = bit_at(mat[CW'(c)], idx);
            p1 = bit_at(mat[CW'(c)], idx + 1);
            if (h == d + 1) begin
              p2  = 1'b0;
              idx = idx + 2;
              h   = h - 1;
            end else begin
              p2  = bit_at(mat[CW'(c)], idx + 2);
              idx = idx + 3;
              h   = h - 2;
            end
            sb = p0 ^ p1 ^ p2;
            cb = (p0 & p1) | (p2 & (p0 ^ p1));
            nmat[CW'(c)] = with_bit(nmat[CW'(c)], ncnt[CW'(c)], sb);
            ncnt[CW'(c)] = ncnt[CW'(c)] + 1;
            if (c + 1 < PW) begin
              nmat[CW'(c + 1)] = with_bit(nmat[CW'(c + 1)], ncnt[CW'(c + 1)], cb);
              ncnt[CW'(c + 1)] = ncnt[CW'(c + 1)] + 1;
            end
          end
        end
        for (int r = 0; r < WIDTH; r++) begin
          if (r >= idx && r < cnt[CW'(c)]) begin
            nmat[CW'(c)] = with_bit(nmat[CW'(c)], ncnt[CW'(c)], bit_at(mat[CW'(c)], r));
            ncnt[CW'(c)] = ncnt[CW'(c)] + 1;
          end
        end
      end
      for (int c = 0; c < PW; c++) begin
        mat[CW'(c)] = nmat[CW'(c)];
        cnt[CW'(c)] = ncnt[CW'(c)];
      end
    end
    for (int c = 0; c < PW; c++) begin
      row0_d = row0_d | (PW'(mat[CW'(c)][0]) << c);
      row1_d = row1_d | (PW'(mat[CW'(c)][1]) << c);
    end
`ifdef DADDA_APPROX_EN
    // Low columns were kept out of the tree, so row1 is zero there and no carry leaves them.
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (i + j < LOW_COLS) row0_d = row0_d | (PW'(bit_at(a_q, j) & bit_at(b_q, i)) << (i + j));
      end
    end
`endif
  end

  assign y_d = row0_q + row1_q;

  assign ld3       = !v3_q | out_ready;
  assign ld2       = !v2_q | ld3;
  assign ld1       = !v1_q | ld2;
  assign in_ready  = ld1;
  assign out_valid = v3_q;
  assign out_y     = y_q;
  assign out_tag   = tag3_q;
  assign busy      = v1_q | v2_q | v3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      tag1_q <= '0;
      row0_q <= '0;
      row1_q <= '0;
      tag2_q <= '0;
      y_q    <= '0;
      tag3_q <= '0;
    end else begin
      if (ld1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          a_q    <= in_a;
          b_q    <= in_b;
          tag1_q <= in_tag;
        end
      end
      if (ld2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          row0_q <= row0_d;
          row1_q <= row1_d;
          tag2_q <= tag1_q;
        end
      end
      if (ld3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          y_q    <= y_d;
          tag3_q <= tag2_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_dadda_mult_pipe.sv
// tb/tb_dadda_mult_pipe.sv - randomized self-checking bench for dadda_mult_pipe
// Honours DADDA_APPROX_EN: the 8-bit instance then uses APPROX_COLS=4 in the reference.
module tb_dadda_mult_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

`ifdef DADDA_APPROX_EN
  localparam int K8 = 4;
  localparam logic [15:0] FF_FF_Y = 16'hFDDF;
`else
  localparam int K8 = 0;
  localparam logic [15:0] FF_FF_Y = 16'hFE01;
`endif

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] out_y;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
  logic [15:0] w_in_a, w_in_b;
  logic [3:0]  w_in_tag, w_out_tag;
  logic [31:0] w_out_y;

  dadda_mult_pipe #(.WIDTH(8), .TAG_W(4), .APPROX_COLS(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag), .busy(busy)
  );

  dadda_mult_pipe #(.WIDTH(16), .TAG_W(4), .APPROX_COLS(0)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a),
    .in_b(w_in_b), .in_tag(w_in_tag), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_y(w_out_y), .out_tag(w_out_tag), .busy(w_busy)
  );

  int          n_tests, n_fail, n_emit;
  logic [15:0] exp_y_q[$];
  logic [3:0]  exp_tag_q[$];
  logic        stall_prev;
  logic [15:0] y_prev;
  logic [3:0]  tag_prev;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Product from its definition: OR of the low-column partial products, plain sum of the rest.
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input int w, input int k);
    logic [63:0] low, high;
    if (k == 0) return a * b;
    low  = '0;
    high = '0;
    for (int i = 0; i < w; i++) begin
      for (int j = 0; j < w; j++) begin
        if ((((a >> j) & (b >> i)) & 64'd1) != 64'd0) begin
          if (i + j < k) low = low | (64'd1 << (i + j));
          else high = high + (64'd1 << (i + j));
        end
      end
    end
    return high | low;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
    return 16'(ref_mul(64'(a), 64'(b), 8, K8));
  endfunction

  task automatic tick(output bit acc);
    @(negedge clk);
    check("in_ready_rule", 64'(in_ready), 64'(!(exp_y_q.size() == 3 && !out_ready)));
    check("busy", 64'(busy), 64'(exp_y_q.size() != 0));
    if (stall_prev) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_y", 64'(out_y), 64'(y_prev));
      check("hold_tag", 64'(out_tag), 64'(tag_prev));
    end
    if (out_valid && out_ready) begin
      n_emit++;
      if (exp_y_q.size() == 0) check("spurious_out", 64'd1, 64'd0);
      else begin
        check("out_y", 64'(out_y), 64'(exp_y_q.pop_front()));
        check("out_tag", 64'(out_tag), 64'(exp_tag_q.pop_front()));
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      exp_y_q.push_back(ref8(in_a, in_b));
      exp_tag_q.push_back(in_tag);
    end
    stall_prev = out_valid && !out_ready;
    y_prev     = out_y;
    tag_prev   = out_tag;
    @(posedge clk);
    #1;
  endtask

  task automatic one_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag, input logic [15:0] exp_y);
    int edges;
    bit acc;
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b1;
    tick(acc);
    check({name, "_accept"}, 64'(acc), 64'd1);
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 10) begin
      tick(acc);
      edges++;
    end
    check({name, "_latency"}, 64'(edges), 64'd3);
    check({name, "_y"}, 64'(out_y), 64'(exp_y));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    tick(acc);
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_y_q.size() != 0; i++) tick(acc);
    check("drain_empty", 64'(exp_y_q.size()), 64'd0);
  endtask

  task automatic random_run(input string name, input int nops, input int rdy_pct);
    int issued, emit0;
    bit acc;
    issued = 0;
    emit0  = n_emit;
    for (int cyc = 0; cyc < 20000 && (issued < nops || exp_y_q.size() != 0); cyc++) begin
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      in_valid  = (issued < nops) && ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_tag    = 4'(issued);
      tick(acc);
      if (acc) issued++;
    end
    in_valid = 1'b0;
    check({name, "_issued"}, 64'(issued), 64'(nops));
    check({name, "_emitted"}, 64'(n_emit - emit0), 64'(nops));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    logic [15:0] wa [3];
    logic [15:0] wb [3];
    logic [31:0] wy [3];
    int got_n;

    n_tests = 0; n_fail = 0; n_emit = 0;
    stall_prev = 1'b0; y_prev = '0; tag_prev = '0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_tag = '0; w_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_w16_out_valid", 64'(w_out_valid), 64'd0);
    rst_n = 1'b1;
    tick(acc);

    one_op("ff_ff", 8'hFF, 8'hFF, 4'h5, FF_FF_Y);
    one_op("zero_a5", 8'h00, 8'hA5, 4'h6, 16'h0000);
    one_op("one_one", 8'h01, 8'h01, 4'h7, 16'h0001);

    wa = '{16'hFFFF, 16'h1234, 16'h8000};
    wb = '{16'hFFFF, 16'h0002, 16'h8000};
    wy = '{32'hFFFE0001, 32'h00002468, 32'h40000000};
    got_n = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) begin
        w_in_valid = 1'b1; w_in_a = wa[c]; w_in_b = wb[c]; w_in_tag = 4'(c);
      end else w_in_valid = 1'b0;
      @(negedge clk);
      if (c < 3) check("w16_in_ready", 64'(w_in_ready), 64'd1);
      if (w_out_valid) begin
        if (got_n < 3) begin
          check("w16_cycle", 64'(c), 64'(3 + got_n));
          check("w16_y", 64'(w_out_y), 64'(wy[got_n]));
          check("w16_tag", 64'(w_out_tag), 64'(got_n));
        end
        got_n++;
      end
      @(posedge clk);
      #1;
    end
    check("w16_count", 64'(got_n), 64'd3);

    random_run("bp", 10, 30);
    drain();

    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_tag = 4'hA;
    tick(acc);
    in_valid = 1'b0;
    tick(acc);
    tick(acc);
    check("bub_s3_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_tag = 4'hB;
    check("bub_rdy1", 64'(in_ready), 64'd1);
    tick(acc);
    check("bub_acc1", 64'(acc), 64'd1);
    in_a = 8'($urandom); in_tag = 4'hC;
    check("bub_rdy2", 64'(in_ready), 64'd1);
    tick(acc);
    check("bub_acc2", 64'(acc), 64'd1);
    in_tag = 4'hD;
    check("bub_rdy3", 64'(in_ready), 64'd0);
    check("bub_busy", 64'(busy), 64'd1);
    tick(acc);
    check("bub_acc3", 64'(acc), 64'd0);
    drain();

    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_tag = 4'(k);
      tick(acc);
    end
    in_valid = 1'b0;
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    exp_y_q.delete();
    exp_tag_q.delete();
    stall_prev = 1'b0;
    tick(acc);
    rst_n = 1'b1;
    repeat (5) tick(acc);
    check("post_rst_idle", 64'(out_valid), 64'd0);
    one_op("rst_3x5", 8'd3, 8'd5, 4'h3, 16'h000F);

    random_run("rand", 1000, 60);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
